// File: rtl/switch_debounce_irq_ctrl_pkg.sv
// Shared register map, CTRL bit positions and small helpers for the
// switch debounce / interrupt controller.
package switch_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int CTRL_BOTH_EDGES = 0;
    localparam int CTRL_BYPASS     = 1;

    // Interrupt request: any captured event whose mask bit is enabled.
    function automatic logic irq_pending(input logic [31:0] cap, input logic [31:0] mask);
        return |(cap & mask);
    endfunction

endpackage

// File: rtl/switch_debounce_irq_ctrl_if.sv
// Avalon-MM slave bus bundle seen by the switch controller.
interface switch_debounce_irq_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/switch_debounce_irq_ctrl_bit.sv
// One switch lane: 2-FF synchroniser, tick-sampled debounce counter,
// accepted level and single-clock rise/fall pulses.
module switch_debounce_bit #(
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    input  logic tick,
    input  logic bypass,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(STABLE_N) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_N - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;

    // Decide whether the synchronised level replaces the accepted level this clock.
    always_comb begin
        accept_s = 1'b0;
        if (sync2_r == deb_r) begin
            accept_s = 1'b0;
        end else if (bypass) begin
            accept_s = 1'b1;
        end else if (tick && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Two-stage synchroniser for the asynchronous switch pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= in_bit;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter, accepted level and edge pulses; a reverting glitch zeroes the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= accept_s & sync2_r;
            fall_r <= accept_s & ~sync2_r;
            if (accept_s) begin
                deb_r <= sync2_r;
                cnt_r <= {CNT_W{1'b0}};
            end else if (bypass) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (tick) begin
                if (sync2_r == deb_r) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign deb  = deb_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/switch_debounce_irq_ctrl.sv
// Avalon-MM switch controller: per-switch debounce lanes, shared sample
// prescaler, IRQMASK/EDGECAP/CTRL registers, registered read mux and irq.
module switch_debounce_irq_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    switch_debounce_irq_ctrl_if.slave     bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    localparam int              PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]  ps_r;
    logic             tick_s;
    logic             wr_s;
    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] qual_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [1:0]       ctrl_r;
    logic [31:0]      rdata_s;
    logic [31:0]      readdata_r;
    logic             irq_r;
    logic             unused_wdata_s;

    assign tick_s         = (ps_r == PS_LAST);
    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign unused_wdata_s = ^bus.writedata;

    // Sample-tick prescaler: one tick every TICK_DIV clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_r <= {PS_W{1'b0}};
        end else begin
            ps_r <= ps_r + PS_W'(1'b1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            switch_debounce_bit #(
                .STABLE_N(STABLE_N)
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .in_bit  (in_port[gi]),
                .tick    (tick_s),
                .bypass  (ctrl_r[CTRL_BYPASS]),
                .deb     (deb_s[gi]),
                .rise    (rise_s[gi]),
                .fall    (fall_s[gi])
            );
        end
    endgenerate

    // Edge qualification (falling edges only count in both-edges mode) and EDGECAP clear mask.
    always_comb begin
        qual_s = rise_s | (fall_s & {WIDTH{ctrl_r[CTRL_BOTH_EDGES]}});
        clr_s  = {WIDTH{1'b0}};
        if (wr_s && (bus.address == ADDR_EDGECAP)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Software registers; a new edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r <= {WIDTH{1'b0}};
            edgecap_r <= {WIDTH{1'b0}};
            ctrl_r    <= 2'b00;
        end else begin
            edgecap_r <= (edgecap_r & ~clr_s) | qual_s;
            if (wr_s && (bus.address == ADDR_IRQMASK)) begin
                irqmask_r <= bus.writedata[WIDTH-1:0];
            end else begin
                irqmask_r <= irqmask_r;
            end
            if (wr_s && (bus.address == ADDR_CTRL)) begin
                ctrl_r <= bus.writedata[1:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.address)
            ADDR_DATA:    rdata_s = 32'(deb_s);
            ADDR_IRQMASK: rdata_s = 32'(irqmask_r);
            ADDR_EDGECAP: rdata_s = 32'(edgecap_r);
            ADDR_CTRL:    rdata_s = {30'h0000_0000, ctrl_r};
            default:      rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered read data and interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= rdata_s;
            irq_r      <= irq_pending(32'(edgecap_r), 32'(irqmask_r));
        end
    end

    assign bus.readdata = readdata_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_switch_debounce_irq_ctrl.sv
// Bench for switch_debounce_irq_ctrl: register table, directed corner
// sequences and random traffic, all checked against a window-based model.
module tb_switch_debounce_irq_ctrl;
    import switch_ctrl_pkg::*;

    localparam int W  = 18;
    localparam int TD = 4;
    localparam int SN = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port;
    logic         irq;

    switch_debounce_irq_ctrl_if bus();

    switch_debounce_irq_ctrl #(.WIDTH(W), .TICK_DIV(TD), .STABLE_N(SN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pin history, tick-sample window, visible registers.
    logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall, m_cap, m_mask;
    logic [1:0]   m_ctrl;
    logic [31:0]  m_rd;
    logic         m_irq;
    int           m_edges;
    logic [W-1:0] m_samp[$];

    typedef struct {
        string       name;
        logic [1:0]  addr;
        bit          do_wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0;
        m_cap = '0; m_mask = '0; m_ctrl = 2'b00; m_rd = 32'h0; m_irq = 1'b0;
        m_edges = 0;
        m_samp.delete();
    endtask

    // A level is accepted once the last SN tick samples all differ from it.
    task automatic model_step();
        logic [W-1:0] acc, qual, clr;
        logic [31:0]  rd;
        logic         wr;
        bit           tick;
        tick = (m_edges % TD) == (TD - 1);
        acc  = '0;
        if (m_ctrl[1]) begin
            m_samp.delete();
            acc = m_s2 ^ m_deb;
        end else if (tick) begin
            m_samp.push_back(m_s2);
            if (m_samp.size() > SN) void'(m_samp.pop_front());
            if (m_samp.size() == SN) begin
                acc = {W{1'b1}};
                foreach (m_samp[i]) acc &= (m_samp[i] ^ m_deb);
            end
        end
        qual = m_rise | (m_fall & {W{m_ctrl[0]}});
        wr   = bus.chipselect & ~bus.write_n;
        clr  = (wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
        case (bus.address)
            2'd0:    rd = 32'(m_deb);
            2'd1:    rd = 32'(m_mask);
            2'd2:    rd = 32'(m_cap);
            default: rd = {30'h0, m_ctrl};
        endcase
        m_rd   = rd;
        m_irq  = |(m_cap & m_mask);
        m_cap  = (m_cap & ~clr) | qual;
        if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
        if (wr && bus.address == 2'd3) m_ctrl = bus.writedata[1:0];
        m_rise = acc & m_s2;
        m_fall = acc & ~m_s2;
        m_deb  = m_deb ^ acc;
        m_s2   = m_s1;
        m_s1   = in_port;
        m_edges++;
    endtask

    task automatic cyc();
        if (reset_n) model_step();
        @(posedge clk);
        #1;
        check("model_readdata", bus.readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        cyc();
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        cyc();
        bus.write_n = 1'b1; bus.chipselect = 1'b0; bus.writedata = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          first, hits, n;

        vecs[0] = '{"irqmask_all",  2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0003_FFFF};
        vecs[1] = '{"irqmask_5a5a", 2'd1, 1'b1, 32'hA5A5_5A5A, 32'h0001_5A5A};
        vecs[2] = '{"ctrl_all",     2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[3] = '{"ctrl_zero",    2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{"data_ro",      2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{"edgecap_w1c",  2'd2, 1'b1, 32'h0000_FFFF, 32'h0000_0000};
        vecs[6] = '{"irqmask_zero", 2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000};

        model_reset();
        in_port = {W{1'b1}};
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;

        // 1: reset holds everything at zero, then all switches settle high.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_readdata", bus.readdata, 32'h0);
            check("reset_irq", 32'(irq), 32'h0);
        end
        reset_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (first == 0 && bus.readdata == 32'h0003_FFFF) first = i;
        end
        check("settle_window", 32'(first >= 11 && first <= 14), 32'h1);
        wr(ADDR_EDGECAP, 32'h0003_FFFF);
        in_port = '0;
        run(20);

        // Register table.
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // 2: a two-tick glitch is rejected, a long hold is accepted.
        in_port[0] = 1'b1;
        run(2 * TD);
        in_port[0] = 1'b0;
        run(20);
        rd(ADDR_DATA, d);    check("glitch_data", d, 32'h0);
        rd(ADDR_EDGECAP, d); check("glitch_edgecap", d, 32'h0);
        in_port[0] = 1'b1;
        run(20);
        rd(ADDR_DATA, d);    check("hold_data", d, 32'h1);
        rd(ADDR_EDGECAP, d); check("hold_edgecap", d, 32'h1);
        wr(ADDR_EDGECAP, 32'h1);

        // 3: masked interrupt asserts with EDGECAP and drops after the clear.
        wr(ADDR_IRQMASK, 32'h1);
        in_port[0] = 1'b0;
        run(20);
        in_port[0] = 1'b1;
        bus.address = ADDR_EDGECAP;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (first == 0 && bus.readdata[0]) begin
                first = i;
                check("irq_with_edgecap", 32'(irq), 32'h1);
            end
            if (first == 0) check("irq_before_edge", 32'(irq), 32'h0);
        end
        check("irq_edge_seen", 32'(first != 0), 32'h1);
        wr(ADDR_EDGECAP, 32'h1);
        check("irq_clear_same_clk", 32'(irq), 32'h1);
        cyc();
        check("irq_clear_next_clk", 32'(irq), 32'h0);
        wr(ADDR_IRQMASK, 32'h0);
        in_port[0] = 1'b0;
        hits = 0;
        for (int i = 0; i < 20; i++) begin cyc(); if (irq) hits++; end
        in_port[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin cyc(); if (irq) hits++; end
        check("irq_masked", 32'(hits), 32'h0);
        rd(ADDR_EDGECAP, d); check("masked_edgecap", d, 32'h1);
        wr(ADDR_EDGECAP, 32'h0003_FFFF);

        // 4: falling edges are captured only in both-edges mode.
        in_port[5] = 1'b1;
        run(20);
        wr(ADDR_EDGECAP, 32'h20);
        in_port[5] = 1'b0;
        run(20);
        rd(ADDR_EDGECAP, d); check("fall_rising_mode", d, 32'h0);
        in_port[5] = 1'b1;
        run(20);
        wr(ADDR_EDGECAP, 32'h20);
        wr(ADDR_CTRL, 32'h1);
        in_port[5] = 1'b0;
        run(20);
        rd(ADDR_EDGECAP, d); check("fall_both_mode", d, 32'h20);
        wr(ADDR_EDGECAP, 32'h20);
        wr(ADDR_CTRL, 32'h0);

        // 5: clear landing with bit2's edge pulse leaves the bit set.
        in_port[2] = 1'b1;
        n = 0;
        while (!m_rise[2] && n < 60) begin cyc(); n++; end
        check("setwins_pulse_found", 32'(m_rise[2]), 32'h1);
        wr(ADDR_EDGECAP, 32'h4);
        rd(ADDR_EDGECAP, d); check("set_wins", d, 32'h4);
        wr(ADDR_EDGECAP, 32'h4);
        rd(ADDR_EDGECAP, d); check("clear_after_setwins", d, 32'h0);

        // 6: bypass follows the pin; deb moves 3 clks after it, readdata one more.
        wr(ADDR_CTRL, 32'h2);
        run(4);
        bus.address = ADDR_DATA;
        in_port[7] = 1'b1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (first == 0 && bus.readdata[7]) first = i;
        end
        check("bypass_rise_latency", 32'(first), 32'd4);
        in_port[7] = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (first == 0 && !bus.readdata[7]) first = i;
        end
        check("bypass_fall_latency", 32'(first), 32'd4);
        rd(ADDR_EDGECAP, d); check("bypass_edgecap", d, 32'h80);
        wr(ADDR_EDGECAP, 32'h80);
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_IRQMASK, 32'h200);

        // Reset in the middle of a debounce: the count restarts from zero.
        in_port[9] = 1'b1;
        n = 0;
        while (!(m_samp.size() >= 2 && m_samp[m_samp.size()-1][9] &&
                 m_samp[m_samp.size()-2][9] && !m_deb[9]) && n < 60) begin
            cyc(); n++;
        end
        check("midreset_cnt2_found", 32'(n < 60), 32'h1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_readdata", bus.readdata, 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        run(2);
        reset_n = 1'b1;
        rd(ADDR_IRQMASK, d); check("midreset_irqmask", d, 32'h0);
        rd(ADDR_CTRL, d);    check("midreset_ctrl", d, 32'h0);
        rd(ADDR_EDGECAP, d); check("midreset_edgecap", d, 32'h0);
        run(2 * TD - 3);
        rd(ADDR_DATA, d);    check("midreset_two_ticks", d, 32'h0);
        run(10);
        rd(ADDR_DATA, d);    check("midreset_settled", d, 32'(in_port));
        wr(ADDR_EDGECAP, 32'h0003_FFFF);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
            bus.address    = 2'($urandom_range(0, 3));
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 7) != 0);
            bus.writedata  = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
